// File: rtl/meta_array_rmw_ctrl.sv
// Client-side controller for a WAYS x DW x SETS two-port metadata array:
// zero-sweeps the array after reset, then runs a one-per-cycle read-modify-write engine.
module meta_array_rmw_ctrl #(
    parameter int SETS = 512,
    parameter int WAYS = 4,
    parameter int DW   = 2,
    localparam int AW  = $clog2(SETS),
    localparam int WW  = $clog2(WAYS)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          io_req_valid,
    output logic          io_req_ready,
    input  logic [AW-1:0] io_req_set,
    input  logic [WW-1:0] io_req_way,
    input  logic [1:0]    io_req_op,
    input  logic [DW-1:0] io_req_data,
    output logic          io_resp_valid,
    output logic [DW-1:0] io_resp_old,
    output logic [DW-1:0] io_resp_new,
    output logic          io_init_done,
    output logic [AW-1:0] io_sram_r_addr,
    input  logic [DW-1:0] io_sram_r_data_0,
    input  logic [DW-1:0] io_sram_r_data_1,
    input  logic [DW-1:0] io_sram_r_data_2,
    input  logic [DW-1:0] io_sram_r_data_3,
    output logic          io_sram_w_en,
    output logic [AW-1:0] io_sram_w_addr,
    output logic [DW-1:0] io_sram_w_data_0,
    output logic [DW-1:0] io_sram_w_data_1,
    output logic [DW-1:0] io_sram_w_data_2,
    output logic [DW-1:0] io_sram_w_data_3,
    output logic [WAYS-1:0] io_sram_w_maskOH
);

    localparam logic [1:0]    OP_WRITE  = 2'd0;
    localparam logic [1:0]    OP_INC    = 2'd1;
    localparam logic [1:0]    OP_DEC    = 2'd2;
    localparam logic [1:0]    OP_CLRSET = 2'd3;
    localparam logic [DW-1:0] VAL_MAX   = {DW{1'b1}};
    localparam logic [DW-1:0] VAL_ZERO  = {DW{1'b0}};
    localparam logic [DW-1:0] VAL_ONE   = {{(DW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] LAST_SET  = AW'(SETS - 1);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic logic [DW-1:0] sat_inc(input logic [DW-1:0] v);
        if (v == VAL_MAX) begin
            return v;
        end else begin
            return v + VAL_ONE;
        end
    endfunction

    function automatic logic [DW-1:0] sat_dec(input logic [DW-1:0] v);
        if (v == VAL_ZERO) begin
            return v;
        end else begin
            return v - VAL_ONE;
        end
    endfunction

    function automatic logic [WAYS-1:0] way_onehot(input logic [WW-1:0] w);
        logic [WAYS-1:0] m;
        m    = {WAYS{1'b0}};
        m[w] = 1'b1;
        return m;
    endfunction

    state_t                  state_r, state_s;
    logic [AW-1:0]           cnt_r;
    logic                    init_done_r;
    logic                    s1_valid_r;
    logic [AW-1:0]           s1_set_r;
    logic [WW-1:0]           s1_way_r;
    logic [1:0]              s1_op_r;
    logic [DW-1:0]           s1_data_r;
    logic                    prev_valid_r;
    logic [AW-1:0]           prev_set_r;
    logic [WAYS-1:0][DW-1:0] prev_vec_r;

    logic [WAYS-1:0][DW-1:0] rd_vec_s, base_s, wvec_s, out_vec_s;
    logic [DW-1:0]           old_s, new_s, resp_old_s;
    logic [WAYS-1:0]         mask_s;
    logic                    fwd_s, fire_s, s1_act_s;

    assign rd_vec_s = {io_sram_r_data_3, io_sram_r_data_2, io_sram_r_data_1, io_sram_r_data_0};
    assign fire_s   = io_req_valid & io_req_ready;
    assign s1_act_s = s1_valid_r & (state_r == ST_RUN) & ~reset;

    // S1 merge: the array write from the previous cycle is not yet visible in r_data,
    // so a same-set predecessor supplies the base vector instead.
    always_comb begin
        fwd_s  = prev_valid_r && (prev_set_r == s1_set_r);
        base_s = fwd_s ? prev_vec_r : rd_vec_s;
        old_s  = base_s[s1_way_r];
        case (s1_op_r)
            OP_WRITE:  new_s = s1_data_r;
            OP_INC:    new_s = sat_inc(old_s);
            OP_DEC:    new_s = sat_dec(old_s);
            OP_CLRSET: new_s = VAL_ZERO;
            default:   new_s = old_s;
        endcase
        wvec_s = base_s;
        if (s1_op_r == OP_CLRSET) begin
            wvec_s     = {(WAYS*DW){1'b0}};
            mask_s     = {WAYS{1'b1}};
            resp_old_s = VAL_ZERO;
        end else begin
            wvec_s[s1_way_r] = new_s;
            mask_s           = way_onehot(s1_way_r);
            resp_old_s       = old_s;
        end
    end

    // Next-state and port drive; every output is forced low while reset is asserted.
    always_comb begin
        state_s          = state_r;
        io_req_ready     = 1'b0;
        io_resp_valid    = 1'b0;
        io_resp_old      = VAL_ZERO;
        io_resp_new      = VAL_ZERO;
        io_sram_r_addr   = {AW{1'b0}};
        io_sram_w_en     = 1'b0;
        io_sram_w_addr   = {AW{1'b0}};
        io_sram_w_maskOH = {WAYS{1'b0}};
        out_vec_s        = {(WAYS*DW){1'b0}};
        if (reset) begin
            state_s = ST_INIT;
        end else begin
            case (state_r)
                ST_INIT: begin
                    io_sram_w_en     = 1'b1;
                    io_sram_w_addr   = cnt_r;
                    io_sram_w_maskOH = {WAYS{1'b1}};
                    if (cnt_r == LAST_SET) begin
                        state_s = ST_RUN;
                    end else begin
                        state_s = ST_INIT;
                    end
                end
                ST_RUN: begin
                    io_req_ready   = 1'b1;
                    io_sram_r_addr = io_req_set;
                    if (s1_valid_r) begin
                        io_sram_w_en     = 1'b1;
                        io_sram_w_addr   = s1_set_r;
                        io_sram_w_maskOH = mask_s;
                        out_vec_s        = wvec_s;
                        io_resp_valid    = 1'b1;
                        io_resp_old      = resp_old_s;
                        io_resp_new      = new_s;
                    end else begin
                        out_vec_s = {(WAYS*DW){1'b0}};
                    end
                end
                default: begin
                    state_s = ST_INIT;
                end
            endcase
        end
    end

    assign io_sram_w_data_0 = out_vec_s[0];
    assign io_sram_w_data_1 = out_vec_s[1];
    assign io_sram_w_data_2 = out_vec_s[2];
    assign io_sram_w_data_3 = out_vec_s[3];
    assign io_init_done     = init_done_r;

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_INIT;
        end else begin
            state_r <= state_s;
        end
    end

    // Init sweep counter and the sticky done flag raised after the last set is written.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_r       <= {AW{1'b0}};
            init_done_r <= 1'b0;
        end else if (state_r == ST_INIT) begin
            cnt_r       <= cnt_r + {{(AW-1){1'b0}}, 1'b1};
            init_done_r <= (cnt_r == LAST_SET);
        end else begin
            cnt_r       <= cnt_r;
            init_done_r <= init_done_r;
        end
    end

    // S0->S1 request capture and the one-deep forwarding record of the last S1 write.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid_r   <= 1'b0;
            s1_set_r     <= {AW{1'b0}};
            s1_way_r     <= {WW{1'b0}};
            s1_op_r      <= 2'd0;
            s1_data_r    <= VAL_ZERO;
            prev_valid_r <= 1'b0;
            prev_set_r   <= {AW{1'b0}};
            prev_vec_r   <= {(WAYS*DW){1'b0}};
        end else begin
            s1_valid_r   <= fire_s;
            if (fire_s) begin
                s1_set_r  <= io_req_set;
                s1_way_r  <= io_req_way;
                s1_op_r   <= io_req_op;
                s1_data_r <= io_req_data;
            end else begin
                s1_set_r  <= s1_set_r;
                s1_way_r  <= s1_way_r;
                s1_op_r   <= s1_op_r;
                s1_data_r <= s1_data_r;
            end
            prev_valid_r <= s1_act_s;
            prev_set_r   <= s1_set_r;
            prev_vec_r   <= wvec_s;
        end
    end

endmodule

// File: tb/tb_meta_array_rmw_ctrl.sv
// Directed bench for meta_array_rmw_ctrl with a behavioural two-port array
// (registered read, masked write, read-during-write returns old data).
module tb_meta_array_rmw_ctrl;

    localparam logic [1:0] OP_WRITE  = 2'd0;
    localparam logic [1:0] OP_INC    = 2'd1;
    localparam logic [1:0] OP_DEC    = 2'd2;
    localparam logic [1:0] OP_CLRSET = 2'd3;

    logic       clock = 1'b0;
    logic       reset;
    logic       io_req_valid;
    logic       io_req_ready;
    logic [8:0] io_req_set;
    logic [1:0] io_req_way;
    logic [1:0] io_req_op;
    logic [1:0] io_req_data;
    logic       io_resp_valid;
    logic [1:0] io_resp_old;
    logic [1:0] io_resp_new;
    logic       io_init_done;
    logic [8:0] io_sram_r_addr;
    logic [1:0] io_sram_r_data_0, io_sram_r_data_1, io_sram_r_data_2, io_sram_r_data_3;
    logic       io_sram_w_en;
    logic [8:0] io_sram_w_addr;
    logic [1:0] io_sram_w_data_0, io_sram_w_data_1, io_sram_w_data_2, io_sram_w_data_3;
    logic [3:0] io_sram_w_maskOH;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0][1:0] mem [512];
    logic [3:0][1:0] rd_q;
    logic [3:0][1:0] wd_v;

    always #5 clock = ~clock;

    meta_array_rmw_ctrl dut (
        .clock(clock), .reset(reset),
        .io_req_valid(io_req_valid), .io_req_ready(io_req_ready),
        .io_req_set(io_req_set), .io_req_way(io_req_way),
        .io_req_op(io_req_op), .io_req_data(io_req_data),
        .io_resp_valid(io_resp_valid), .io_resp_old(io_resp_old), .io_resp_new(io_resp_new),
        .io_init_done(io_init_done), .io_sram_r_addr(io_sram_r_addr),
        .io_sram_r_data_0(io_sram_r_data_0), .io_sram_r_data_1(io_sram_r_data_1),
        .io_sram_r_data_2(io_sram_r_data_2), .io_sram_r_data_3(io_sram_r_data_3),
        .io_sram_w_en(io_sram_w_en), .io_sram_w_addr(io_sram_w_addr),
        .io_sram_w_data_0(io_sram_w_data_0), .io_sram_w_data_1(io_sram_w_data_1),
        .io_sram_w_data_2(io_sram_w_data_2), .io_sram_w_data_3(io_sram_w_data_3),
        .io_sram_w_maskOH(io_sram_w_maskOH)
    );

    assign wd_v = {io_sram_w_data_3, io_sram_w_data_2, io_sram_w_data_1, io_sram_w_data_0};
    assign {io_sram_r_data_3, io_sram_r_data_2, io_sram_r_data_1, io_sram_r_data_0} = rd_q;

    // Array model: the read samples before the write lands, so same-address reads see old data.
    always @(posedge clock) begin
        rd_q <= mem[io_sram_r_addr];
        if (io_sram_w_en) begin
            for (int w = 0; w < 4; w++) begin
                if (io_sram_w_maskOH[w]) mem[io_sram_w_addr][w] <= wd_v[w];
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic [8:0] s, input logic [1:0] w, input logic [1:0] op,
                         input logic [1:0] d);
        io_req_valid = 1'b1;
        io_req_set   = s;
        io_req_way   = w;
        io_req_op    = op;
        io_req_data  = d;
        tick();
    endtask

    task automatic idle_cyc();
        io_req_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        io_req_valid = 1'b0;
        io_req_set = 9'd0; io_req_way = 2'd0; io_req_op = 2'd0; io_req_data = 2'd0;
        repeat (3) tick();
        n_checks++;
        if (io_sram_w_en !== 1'b0) begin n_fail++; $display("FAIL reset_w_en: got %b expected 0", io_sram_w_en); end
        n_checks++;
        if (io_req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", io_req_ready); end
        n_checks++;
        if (io_resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b expected 0", io_resp_valid); end
        n_checks++;
        if (io_init_done !== 1'b0) begin n_fail++; $display("FAIL reset_init_done: got %b expected 0", io_init_done); end
    endtask

    // Releases reset and checks the full 512-cycle zero sweep and the RUN entry.
    task automatic test_init(input string tag);
        int bad = 0;
        int first_bad = -1;
        reset = 1'b0;
        #1;
        for (int i = 0; i < 512; i++) begin
            if (io_sram_w_en !== 1'b1 || io_sram_w_addr !== 9'(i) || io_sram_w_maskOH !== 4'b1111 ||
                wd_v !== 8'h00 || io_req_ready !== 1'b0 || io_init_done !== 1'b0 ||
                io_resp_valid !== 1'b0) begin
                bad++;
                if (first_bad < 0) first_bad = i;
            end
            tick();
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL %s_sweep: %0d bad cycles (first %0d) expected 0", tag, bad, first_bad);
        end
        n_checks++;
        if (io_init_done !== 1'b1) begin n_fail++; $display("FAIL %s_done: got %b expected 1", tag, io_init_done); end
        n_checks++;
        if (io_req_ready !== 1'b1) begin n_fail++; $display("FAIL %s_ready: got %b expected 1", tag, io_req_ready); end
        n_checks++;
        if (io_sram_w_en !== 1'b0) begin n_fail++; $display("FAIL %s_idle_w_en: got %b expected 0", tag, io_sram_w_en); end
    endtask

    task automatic test_write_inc();
        io_req_valid = 1'b1; io_req_set = 9'd5; io_req_way = 2'd2;
        io_req_op = OP_WRITE; io_req_data = 2'd3;
        #1;
        n_checks++;
        if (io_sram_r_addr !== 9'd5) begin n_fail++; $display("FAIL wi_r_addr: got %0d expected 5", io_sram_r_addr); end
        issue(9'd5, 2'd2, OP_WRITE, 2'd3);
        n_checks++;
        if (io_resp_valid !== 1'b1 || io_resp_old !== 2'd0 || io_resp_new !== 2'd3) begin
            n_fail++; $display("FAIL wi_resp1: got v=%b old=%0d new=%0d expected v=1 old=0 new=3",
                               io_resp_valid, io_resp_old, io_resp_new);
        end
        n_checks++;
        if (io_sram_w_en !== 1'b1 || io_sram_w_addr !== 9'd5 || io_sram_w_maskOH !== 4'b0100) begin
            n_fail++; $display("FAIL wi_write1: got en=%b addr=%0d mask=%b expected en=1 addr=5 mask=0100",
                               io_sram_w_en, io_sram_w_addr, io_sram_w_maskOH);
        end
        idle_cyc();
        n_checks++;
        if (io_resp_valid !== 1'b0 || io_sram_w_en !== 1'b0) begin
            n_fail++; $display("FAIL wi_gap: got v=%b en=%b expected 0 0", io_resp_valid, io_sram_w_en);
        end
        issue(9'd5, 2'd2, OP_INC, 2'd0);
        n_checks++;
        if (io_resp_old !== 2'd3 || io_resp_new !== 2'd3) begin
            n_fail++; $display("FAIL wi_resp2: got old=%0d new=%0d expected old=3 new=3", io_resp_old, io_resp_new);
        end
        n_checks++;
        if (io_sram_w_en !== 1'b1 || io_sram_w_maskOH !== 4'b0100 || wd_v !== 8'b00_11_00_00) begin
            n_fail++; $display("FAIL wi_write2: got en=%b mask=%b data=%h expected en=1 mask=0100 data=30",
                               io_sram_w_en, io_sram_w_maskOH, wd_v);
        end
        idle_cyc();
    endtask

    task automatic test_back_to_back();
        issue(9'd7, 2'd0, OP_WRITE, 2'd2);
        n_checks++;
        if (io_resp_old !== 2'd0 || io_resp_new !== 2'd2) begin
            n_fail++; $display("FAIL b2b_resp1: got old=%0d new=%0d expected old=0 new=2", io_resp_old, io_resp_new);
        end
        issue(9'd7, 2'd1, OP_INC, 2'd0);
        n_checks++;
        if (io_resp_old !== 2'd0 || io_resp_new !== 2'd1) begin
            n_fail++; $display("FAIL b2b_resp2: got old=%0d new=%0d expected old=0 new=1", io_resp_old, io_resp_new);
        end
        n_checks++;
        if (wd_v !== 8'b00_00_01_10 || io_sram_w_maskOH !== 4'b0010) begin
            n_fail++; $display("FAIL b2b_fwd_write: got data=%h mask=%b expected data=06 mask=0010",
                               wd_v, io_sram_w_maskOH);
        end
        idle_cyc();
    endtask

    task automatic test_same_way();
        issue(9'd9, 2'd3, OP_INC, 2'd0);
        n_checks++;
        if (io_resp_new !== 2'd1) begin n_fail++; $display("FAIL sw_inc1: got %0d expected 1", io_resp_new); end
        issue(9'd9, 2'd3, OP_INC, 2'd0);
        n_checks++;
        if (io_resp_new !== 2'd2) begin n_fail++; $display("FAIL sw_inc2: got %0d expected 2", io_resp_new); end
        issue(9'd9, 2'd3, OP_INC, 2'd0);
        n_checks++;
        if (io_resp_new !== 2'd3) begin n_fail++; $display("FAIL sw_inc3: got %0d expected 3", io_resp_new); end
        issue(9'd9, 2'd3, OP_DEC, 2'd0);
        n_checks++;
        if (io_resp_old !== 2'd3 || io_resp_new !== 2'd2) begin
            n_fail++; $display("FAIL sw_dec: got old=%0d new=%0d expected old=3 new=2", io_resp_old, io_resp_new);
        end
        idle_cyc();
        issue(9'd10, 2'd0, OP_DEC, 2'd0);
        n_checks++;
        if (io_resp_old !== 2'd0 || io_resp_new !== 2'd0 || io_sram_w_en !== 1'b1) begin
            n_fail++; $display("FAIL sw_dec_floor: got old=%0d new=%0d en=%b expected old=0 new=0 en=1",
                               io_resp_old, io_resp_new, io_sram_w_en);
        end
        idle_cyc();
    endtask

    task automatic test_clrset();
        issue(9'd7, 2'd2, OP_CLRSET, 2'd3);
        n_checks++;
        if (io_sram_w_maskOH !== 4'b1111 || wd_v !== 8'h00 || io_sram_w_addr !== 9'd7) begin
            n_fail++; $display("FAIL clr_write: got mask=%b data=%h addr=%0d expected mask=1111 data=00 addr=7",
                               io_sram_w_maskOH, wd_v, io_sram_w_addr);
        end
        n_checks++;
        if (io_resp_old !== 2'd0 || io_resp_new !== 2'd0) begin
            n_fail++; $display("FAIL clr_resp: got old=%0d new=%0d expected 0 0", io_resp_old, io_resp_new);
        end
        issue(9'd7, 2'd0, OP_INC, 2'd0);
        n_checks++;
        if (io_resp_old !== 2'd0 || io_resp_new !== 2'd1 || wd_v !== 8'h01) begin
            n_fail++; $display("FAIL clr_then_inc: got old=%0d new=%0d data=%h expected old=0 new=1 data=01",
                               io_resp_old, io_resp_new, wd_v);
        end
        idle_cyc();
    endtask

    task automatic test_reset_mid();
        issue(9'd20, 2'd1, OP_WRITE, 2'd3);
        idle_cyc();
        issue(9'd21, 2'd0, OP_WRITE, 2'd2);
        io_req_valid = 1'b0;
        reset = 1'b1;
        #1;
        n_checks++;
        if (io_resp_valid !== 1'b0 || io_sram_w_en !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_suppress: got v=%b en=%b expected 0 0", io_resp_valid, io_sram_w_en);
        end
        @(posedge clock);
        #1;
        test_init("reinit");
        issue(9'd20, 2'd1, OP_INC, 2'd0);
        n_checks++;
        if (io_resp_old !== 2'd0 || io_resp_new !== 2'd1) begin
            n_fail++; $display("FAIL rst_mid_cleared: got old=%0d new=%0d expected old=0 new=1", io_resp_old, io_resp_new);
        end
        idle_cyc();
        issue(9'd21, 2'd0, OP_INC, 2'd0);
        n_checks++;
        if (io_resp_old !== 2'd0 || io_resp_new !== 2'd1) begin
            n_fail++; $display("FAIL rst_mid_lost: got old=%0d new=%0d expected old=0 new=1", io_resp_old, io_resp_new);
        end
        idle_cyc();
    endtask

    initial begin
        test_reset();
        test_init("init");
        test_write_inc();
        test_back_to_back();
        test_same_way();
        test_clrset();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
